// File: rtl/procesador_multicycle.sv
// procesador_multicycle: RV32I-subset multicycle processor core.
// The FSM steps FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH; an illegal
// instruction parks it in TRAP until reset. Memories use req/ready handshakes,
// so any number of wait states is tolerated. Every bus output is a flop.
// Ports:
//   CLK, RESET_N      clock (rising edge), asynchronous active-low reset
//   iaddr/ireq        instruction fetch address (PC) and request
//   idata/iready      instruction word and its ready/accept strobe
//   daddr/ddata_w     data address (ALU result) and store data (rs2)
//   ddata_r/dready    load data and its ready/accept strobe
//   dreq/d_rw         data request, 1 = read, 0 = write
//   illegal           sticky illegal-instruction flag
//   instret           64-bit retired-instruction count (only with INSTRET_CNT_EN)
// Optional feature macro: INSTRET_CNT_EN.
module procesador_multicycle #(
    parameter int          n        = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic         CLK,
    input  logic         RESET_N,
    output logic [n-1:0] iaddr,
    output logic         ireq,
    input  logic [n-1:0] idata,
    input  logic         iready,
    output logic [n-1:0] daddr,
    output logic [n-1:0] ddata_w,
    input  logic [n-1:0] ddata_r,
    output logic         dreq,
    output logic         d_rw,
    input  logic         dready,
    output logic         illegal
`ifdef INSTRET_CNT_EN
    ,
    output logic [63:0]  instret
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    localparam logic [n-1:0] PC_STEP = {{(n-3){1'b0}}, 3'b100};
    localparam logic [n-1:0] ZERO    = {n{1'b0}};

    state_t       state_q, state_d;
    logic [n-1:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [n-1:0] alu_q, alu_d, mdr_q, mdr_d;
    logic         ireq_q, ireq_d, dreq_q, dreq_d, d_rw_q, d_rw_d;
    logic         illegal_q, illegal_d;
    logic [n-1:0] regs_q [NREGS];

    logic [6:0]   opcode_s, funct7_s;
    logic [2:0]   funct3_s;
    logic [4:0]   rd_s, rs1_s, rs2_s;
    logic         legal_s, is_load_s, is_store_s, is_branch_s, is_bne_s, is_jal_s;
    logic         alu_src_imm_s, take_s;
    alu_op_t      alu_op_s;
    logic [n-1:0] imm_s, alu_b_s, alu_res_s;
    logic         rf_we_s;
    logic [n-1:0] rf_wdata_s;

    assign opcode_s = ir_q[6:0];
    assign rd_s     = ir_q[11:7];
    assign funct3_s = ir_q[14:12];
    assign rs1_s    = ir_q[19:15];
    assign rs2_s    = ir_q[24:20];
    assign funct7_s = ir_q[31:25];

    // Instruction decode: legality, class flags, ALU operation and immediate.
    always_comb begin
        legal_s       = 1'b1;
        is_load_s     = 1'b0;
        is_store_s    = 1'b0;
        is_branch_s   = 1'b0;
        is_bne_s      = 1'b0;
        is_jal_s      = 1'b0;
        alu_src_imm_s = 1'b1;
        alu_op_s      = ALU_ADD;
        imm_s         = {{(n-12){ir_q[31]}}, ir_q[31:20]};
        case (opcode_s)
            7'b0110011: begin
                alu_src_imm_s = 1'b0;
                case ({funct7_s, funct3_s})
                    10'b0000000_000: alu_op_s = ALU_ADD;
                    10'b0100000_000: alu_op_s = ALU_SUB;
                    10'b0000000_111: alu_op_s = ALU_AND;
                    10'b0000000_110: alu_op_s = ALU_OR;
                    10'b0000000_010: alu_op_s = ALU_SLT;
                    default:         legal_s  = 1'b0;
                endcase
            end
            7'b0010011: begin
                case (funct3_s)
                    3'b000:  alu_op_s = ALU_ADD;
                    3'b111:  alu_op_s = ALU_AND;
                    3'b110:  alu_op_s = ALU_OR;
                    3'b010:  alu_op_s = ALU_SLT;
                    default: legal_s  = 1'b0;
                endcase
            end
            7'b0000011: begin
                is_load_s = 1'b1;
                legal_s   = (funct3_s == 3'b010);
            end
            7'b0100011: begin
                is_store_s = 1'b1;
                legal_s    = (funct3_s == 3'b010);
                imm_s      = {{(n-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            end
            7'b1100011: begin
                is_branch_s = 1'b1;
                is_bne_s    = funct3_s[0];
                legal_s     = (funct3_s[2:1] == 2'b00);
                imm_s       = {{(n-12){ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            end
            7'b1101111: begin
                is_jal_s = 1'b1;
                imm_s    = {{(n-20){ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            end
            default: legal_s = 1'b0;
        endcase
    end

    // ALU on A and either the immediate or B; slt compares signed.
    always_comb begin
        alu_b_s = alu_src_imm_s ? imm_s : b_q;
        case (alu_op_s)
            ALU_ADD: alu_res_s = a_q + alu_b_s;
            ALU_SUB: alu_res_s = a_q - alu_b_s;
            ALU_AND: alu_res_s = a_q & alu_b_s;
            ALU_OR:  alu_res_s = a_q | alu_b_s;
            ALU_SLT: alu_res_s = {{(n-1){1'b0}}, ($signed(a_q) < $signed(alu_b_s))};
            default: alu_res_s = ZERO;
        endcase
        take_s = is_bne_s ? (a_q != b_q) : (a_q == b_q);
    end

    // Next-state, datapath register updates and registered bus outputs.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        alu_d      = alu_q;
        mdr_d      = mdr_q;
        ireq_d     = ireq_q;
        dreq_d     = dreq_q;
        d_rw_d     = d_rw_q;
        illegal_d  = illegal_q;
        rf_we_s    = 1'b0;
        rf_wdata_s = alu_q;
        case (state_q)
            S_FETCH: begin
                // ireq_q is low only in the first cycle after reset release.
                if (ireq_q && iready) begin
                    ir_d    = idata;
                    ireq_d  = 1'b0;
                    state_d = S_DECODE;
                end else begin
                    ireq_d  = 1'b1;
                end
            end
            S_DECODE: begin
                a_d = (int'(rs1_s) < NREGS) ? regs_q[rs1_s] : ZERO;
                b_d = (int'(rs2_s) < NREGS) ? regs_q[rs2_s] : ZERO;
                if (!legal_s) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_d = alu_res_s;
                if (is_branch_s) begin
                    pc_d    = take_s ? (pc_q + imm_s) : (pc_q + PC_STEP);
                    ireq_d  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_jal_s) begin
                    rf_we_s    = 1'b1;
                    rf_wdata_s = pc_q + PC_STEP;
                    pc_d       = pc_q + imm_s;
                    ireq_d     = 1'b1;
                    state_d    = S_FETCH;
                end else if (is_load_s || is_store_s) begin
                    dreq_d  = 1'b1;
                    d_rw_d  = is_load_s;
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dready) begin
                    dreq_d = 1'b0;
                    d_rw_d = 1'b1;
                    if (is_load_s) begin
                        mdr_d   = ddata_r;
                        state_d = S_WB;
                    end else begin
                        pc_d    = pc_q + PC_STEP;
                        ireq_d  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                rf_we_s    = 1'b1;
                rf_wdata_s = is_load_s ? mdr_q : alu_q;
                pc_d       = pc_q + PC_STEP;
                ireq_d     = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                ireq_d    = 1'b0;
                dreq_d    = 1'b0;
                illegal_d = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State, datapath and output registers; reset drops any request in flight.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC[n-1:0];
            ir_q      <= ZERO;
            a_q       <= ZERO;
            b_q       <= ZERO;
            alu_q     <= ZERO;
            mdr_q     <= ZERO;
            ireq_q    <= 1'b0;
            dreq_q    <= 1'b0;
            d_rw_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            ireq_q    <= ireq_d;
            dreq_q    <= dreq_d;
            d_rw_q    <= d_rw_d;
            illegal_q <= illegal_d;
        end
    end

    // Register file write port; x0 and indices beyond NREGS are never written.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= ZERO;
            end
        end else if (rf_we_s && (rd_s != 5'd0) && (int'(rd_s) < NREGS)) begin
            regs_q[rd_s] <= rf_wdata_s;
        end else begin
            regs_q[0] <= ZERO;
        end
    end

    assign iaddr   = pc_q;
    assign ireq    = ireq_q;
    assign daddr   = alu_q;
    assign ddata_w = b_q;
    assign dreq    = dreq_q;
    assign d_rw    = d_rw_q;
    assign illegal = illegal_q;

`ifdef INSTRET_CNT_EN
    logic [63:0] instret_q;
    logic        retire_s;

    // Every entry into FETCH retires an instruction; TRAP never returns to FETCH.
    assign retire_s = (state_q != S_FETCH) && (state_d == S_FETCH);

    // Retired-instruction counter, wraps naturally at 2^64.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            instret_q <= 64'd0;
        end else if (retire_s) begin
            instret_q <= instret_q + 64'd1;
        end else begin
            instret_q <= instret_q;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_procesador_multicycle.sv
// Testbench for procesador_multicycle: behavioural memories with programmable
// wait states, a scoreboard of expected fetch addresses and data transactions
// checked by a negedge monitor, plus directed reset/trap/cycle-count checks.
module tb_procesador_multicycle;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] iaddr, idata, daddr, ddata_w, ddata_r;
    logic        ireq, iready, dreq, d_rw, dready, illegal;
`ifdef INSTRET_CNT_EN
    logic [63:0] instret;
`endif

    procesador_multicycle #(.n(32), .RESET_PC(32'h0000_0000), .NREGS(32)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .iaddr(iaddr), .ireq(ireq), .idata(idata), .iready(iready),
        .daddr(daddr), .ddata_w(ddata_w), .ddata_r(ddata_r),
        .dreq(dreq), .d_rw(d_rw), .dready(dready),
        .illegal(illegal)
`ifdef INSTRET_CNT_EN
        , .instret(instret)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } dexp_t;

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          iwait = 0;
    int          rwait = 3;
    logic        mon_en = 1'b0;
    logic [31:0] imem [64];
    logic [31:0] exp_f [$];
    dexp_t       exp_d [$];
    int          fcyc [$];
    int          exp_dt [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // Memory responder: looks at the freshly updated requests just after each edge.
    initial begin
        int icnt = 0;
        int dcnt = 0;
        int dw;
        iready = 1'b0; dready = 1'b0; idata = 32'h0; ddata_r = 32'h0;
        forever begin
            @(posedge CLK); #1;
            if (ireq) begin
                if (icnt == iwait) begin iready = 1'b1; idata = imem[iaddr[7:2]]; end
                else begin iready = 1'b0; icnt++; end
            end else begin
                iready = 1'b0; icnt = 0;
            end
            dw = d_rw ? rwait : 0;
            if (dreq) begin
                if (dcnt == dw) begin dready = 1'b1; ddata_r = 32'hDEAD_BEEF; end
                else begin dready = 1'b0; dcnt++; end
            end else begin
                dready = 1'b0; dcnt = 0;
            end
        end
    end

    // Scoreboard monitor: every completed handshake pops one expectation.
    always @(negedge CLK) begin
        if (mon_en && ireq && iready) begin
            fcyc.push_back(cyc);
            if (exp_f.size() == 0) chk("fetch_unexpected", {32'h0, iaddr}, 64'hFFFF_FFFF);
            else chk("fetch_addr", {32'h0, iaddr}, {32'h0, exp_f.pop_front()});
        end
        if (mon_en && dreq && dready) begin
            if (exp_d.size() == 0) begin
                chk("data_unexpected", {32'h0, daddr}, 64'hFFFF_FFFF);
            end else begin
                dexp_t e;
                e = exp_d.pop_front();
                chk("data_rw", {63'h0, d_rw}, {63'h0, e.rw});
                chk("data_addr", {32'h0, daddr}, {32'h0, e.addr});
                if (!e.rw) chk("data_wdata", {32'h0, ddata_w}, {32'h0, e.data});
            end
        end
    end

    task automatic chk_reset();
        chk("rst_ireq", {63'h0, ireq}, 64'h0);
        chk("rst_dreq", {63'h0, dreq}, 64'h0);
        chk("rst_d_rw", {63'h0, d_rw}, 64'h1);
        chk("rst_illegal", {63'h0, illegal}, 64'h0);
        chk("rst_daddr", {32'h0, daddr}, 64'h0);
        chk("rst_ddata_w", {32'h0, ddata_w}, 64'h0);
        chk("rst_iaddr", {32'h0, iaddr}, 64'h0);
    endtask

    task automatic run_to_trap(input int limit);
        int k = 0;
        while (!illegal && k < limit) begin @(posedge CLK); #1; k++; end
        chk("trap_reached", {63'h0, illegal}, 64'h1);
    endtask

    task automatic post_checks(input logic [63:0] exp_retired);
        int bad = 0;
        repeat (22) begin
            @(negedge CLK);
            if (ireq || dreq || !illegal) bad++;
        end
        chk("trap_quiet", bad, 64'h0);
        chk("fetch_q_empty", exp_f.size(), 64'h0);
        chk("data_q_empty", exp_d.size(), 64'h0);
        chk("fetch_count", fcyc.size(), exp_dt.size() + 1);
        for (int i = 0; i < exp_dt.size() && i + 1 < fcyc.size(); i++)
            chk($sformatf("cycles_instr%0d", i), fcyc[i+1] - fcyc[i], exp_dt[i]);
`ifdef INSTRET_CNT_EN
        chk("instret", instret, exp_retired);
`else
        if (exp_retired == 64'h0) $display("note: empty program");
`endif
    endtask

    function automatic dexp_t wr(input logic [31:0] a, input logic [31:0] d);
        return '{rw: 1'b0, addr: a, data: d};
    endfunction

    initial begin
        int k;
        RESET_N = 1'b0;
        for (int i = 0; i < 64; i++) imem[i] = 32'hFFFF_FFFF;
        // Program A: ALU ops, stores, a wait-state load, x0 write.
        imem[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
        imem[1]  = enc_i(12'd7, 5'd0, 3'b000, 5'd2, 7'b0010011);
        imem[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        imem[3]  = enc_s(12'd0, 5'd3, 5'd0);
        imem[4]  = enc_i(12'd8, 5'd0, 3'b010, 5'd4, 7'b0000011);
        imem[5]  = enc_s(12'd4, 5'd4, 5'd0);
        imem[6]  = enc_r(7'h20, 5'd3, 5'd4, 3'b000, 5'd5);
        imem[7]  = enc_r(7'h00, 5'd3, 5'd4, 3'b010, 5'd6);
        imem[8]  = enc_i(12'h0FF, 5'd4, 3'b111, 5'd7, 7'b0010011);
        imem[9]  = enc_i(12'h700, 5'd7, 3'b110, 5'd8, 7'b0010011);
        imem[10] = enc_i(12'hFFF, 5'd4, 3'b010, 5'd11, 7'b0010011);
        imem[11] = enc_i(12'd9, 5'd0, 3'b000, 5'd0, 7'b0010011);
        imem[12] = enc_s(12'd12, 5'd5, 5'd0);
        imem[13] = enc_s(12'd16, 5'd6, 5'd0);
        imem[14] = enc_s(12'd20, 5'd8, 5'd0);
        imem[15] = enc_s(12'd24, 5'd7, 5'd0);
        imem[16] = enc_s(12'd28, 5'd11, 5'd0);
        imem[17] = enc_s(12'd32, 5'd0, 5'd0);

        repeat (2) @(posedge CLK); #1;
        chk_reset();
        @(negedge CLK); RESET_N = 1'b1;
        k = 0;
        while (!(dreq && d_rw) && k < 100) begin @(negedge CLK); k++; end
        chk("reach_lw_mem", {63'h0, dreq && d_rw}, 64'h1);
        RESET_N = 1'b0; #1;
        chk_reset();

        for (int i = 0; i <= 18; i++) exp_f.push_back(32'(i * 4));
        exp_d.push_back(wr(32'd0, 32'd12));
        exp_d.push_back('{rw: 1'b1, addr: 32'd8, data: 32'h0});
        exp_d.push_back(wr(32'd4, 32'hDEAD_BEEF));
        exp_d.push_back(wr(32'd12, 32'hDEAD_BEE3));
        exp_d.push_back(wr(32'd16, 32'd1));
        exp_d.push_back(wr(32'd20, 32'h7EF));
        exp_d.push_back(wr(32'd24, 32'hEF));
        exp_d.push_back(wr(32'd28, 32'd1));
        exp_d.push_back(wr(32'd32, 32'd0));
        for (int i = 0; i < 18; i++) exp_dt.push_back((i == 4) ? 8 : 4);
        mon_en = 1'b1;
        @(negedge CLK); RESET_N = 1'b1;
        @(posedge CLK); #1;
        chk("first_edge_ireq", {63'h0, ireq}, 64'h1);
        chk("first_edge_iaddr", {32'h0, iaddr}, 64'h0);
        run_to_trap(600);
        post_checks(64'd18);

        // Program B: jal, taken/not-taken branches, one fetch wait state each.
        @(negedge CLK); RESET_N = 1'b0; #1;
        chk("illegal_cleared", {63'h0, illegal}, 64'h0);
        fcyc.delete(); exp_dt.delete();
        for (int i = 0; i < 64; i++) imem[i] = 32'hFFFF_FFFF;
        imem[0]  = enc_j(21'h20, 5'd9);
        imem[8]  = enc_b(13'h1FF8, 5'd0, 5'd0, 3'b000);
        imem[6]  = enc_b(13'h1FF8, 5'd0, 5'd0, 3'b001);
        imem[7]  = enc_b(13'h000C, 5'd0, 5'd9, 3'b001);
        imem[10] = enc_s(12'd16, 5'd9, 5'd0);
        iwait = 1;
        exp_f.push_back(32'h00); exp_f.push_back(32'h20); exp_f.push_back(32'h18);
        exp_f.push_back(32'h1C); exp_f.push_back(32'h28); exp_f.push_back(32'h2C);
        exp_d.push_back(wr(32'd16, 32'd4));
        exp_dt.push_back(4); exp_dt.push_back(4); exp_dt.push_back(4);
        exp_dt.push_back(4); exp_dt.push_back(5);
        @(negedge CLK); RESET_N = 1'b1;
        run_to_trap(300);
        post_checks(64'd5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
